// File: rtl/apb_ctrl_pkg.sv
// Shared definitions for the APB master/arbiter slice.
//   apb_state_e : APB protocol phase of the master FSM
//   APB_ADDR_W  : default APB address width
//   APB_DATA_W  : default APB data width
package apb_ctrl_pkg;

    localparam int APB_ADDR_W = 3;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } apb_state_e;

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req starting at ptr, wrapping NUM_REQ-1 -> 0, and returns the
// first requester found.
//   req       : request vector
//   ptr       : highest-priority requester index for this search
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : binary index of the granted requester
//   any       : at least one request present
module rr_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    always_comb begin
        int unsigned cand;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(ptr) + i) % NUM_REQ;
            if (!any && req[cand[IDX_W-1:0]]) begin
                any                      = 1'b1;
                grant[cand[IDX_W-1:0]]   = 1'b1;
                grant_idx                = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by NUM_REQ requesters with round-robin arbitration.
// Sequences IDLE -> SETUP -> ACCESS, waits on PREADY for at most TIMEOUT
// ACCESS cycles and returns read data or a timeout error to the owner.
//   PCLK, PRESET          : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester request / one-hot accept pulse
//   req_write/addr/wdata  : packed per-requester payload
//   rsp_valid/rdata/err   : one-hot completion pulse, read data, timeout flag
//   PSEL..PWDATA          : APB master outputs
//   PRDATA, PREADY        : APB slave responses
// Every output is a flop; the payload latch drives the APB bus directly.
module apb_master_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    apb_state_e           state, state_n;
    logic [IDX_W-1:0]     ptr, ptr_n;
    logic [IDX_W-1:0]     owner, owner_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 lat_write, lat_write_n;
    logic [ADDR_W-1:0]    lat_addr, lat_addr_n;
    logic [DATA_W-1:0]    lat_wdata, lat_wdata_n;
    logic                 psel_q, psel_n;
    logic                 penable_q, penable_n;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_n;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_n;
    logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_n;
    logic                 rsp_err_q, rsp_err_n;

    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // Output flops are loaded with the values belonging to the next state,
    // so PSEL/PENABLE/req_ready/rsp_* appear in the same cycle as that state.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        owner_n     = owner;
        cnt_n       = cnt;
        lat_write_n = lat_write;
        lat_addr_n  = lat_addr;
        lat_wdata_n = lat_wdata;
        psel_n      = 1'b0;
        penable_n   = 1'b0;
        req_ready_n = '0;
        rsp_valid_n = '0;
        rsp_rdata_n = '0;
        rsp_err_n   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (grant_any) begin
                    state_n     = ST_SETUP;
                    owner_n     = grant_idx;
                    ptr_n       = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                     : grant_idx + IDX_W'(1);
                    lat_write_n = req_write[grant_idx];
                    lat_addr_n  = req_addr[32'(grant_idx) * ADDR_W +: ADDR_W];
                    lat_wdata_n = req_wdata[32'(grant_idx) * DATA_W +: DATA_W];
                    req_ready_n = grant;
                    psel_n      = 1'b1;
                    cnt_n       = '0;
                end
            end

            ST_SETUP: begin
                state_n   = ST_ACCESS;
                psel_n    = 1'b1;
                penable_n = 1'b1;
            end

            ST_ACCESS: begin
                if (PREADY) begin
                    state_n            = ST_IDLE;
                    rsp_valid_n[owner] = 1'b1;
                    rsp_rdata_n        = lat_write ? '0 : PRDATA;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_n            = ST_IDLE;
                    rsp_valid_n[owner] = 1'b1;
                    rsp_err_n          = 1'b1;
                end else begin
                    cnt_n     = cnt + CNT_W'(1);
                    psel_n    = 1'b1;
                    penable_n = 1'b1;
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            owner       <= '0;
            cnt         <= '0;
            lat_write   <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            owner       <= owner_n;
            cnt         <= cnt_n;
            lat_write   <= lat_write_n;
            lat_addr    <= lat_addr_n;
            lat_wdata   <= lat_wdata_n;
            psel_q      <= psel_n;
            penable_q   <= penable_n;
            req_ready_q <= req_ready_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_rdata_q <= rsp_rdata_n;
            rsp_err_q   <= rsp_err_n;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = lat_write;
    assign PADDR     = lat_addr;
    assign PWDATA    = lat_wdata;
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;

    logic                      PCLK = 1'b0;
    logic                      PRESET;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic                      PSEL, PENABLE, PWRITE;
    logic [ADDR_W-1:0]         PADDR;
    logic [DATA_W-1:0]         PWDATA;
    logic [DATA_W-1:0]         PRDATA;
    logic                      PREADY;

    logic [DATA_W-1:0] slave_mem [8];
    logic [DATA_W-1:0] ref_mem   [8];

    int checks  = 0;
    int errors  = 0;
    int exp_ptr = 0;

    always #5 PCLK = ~PCLK;

    apb_master_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    // Simple APB slave memory
    assign PRDATA = slave_mem[PADDR];
    always @(posedge PCLK)
        if (PSEL && PENABLE && PREADY && PWRITE)
            slave_mem[PADDR] <= PWDATA;

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    // One complete transfer. The expected winner is the first requester in
    // mask at or after exp_ptr (wrapping); waits<0 means PREADY never rises.
    task automatic xfer(input logic [NUM_REQ-1:0] mask, input logic [NUM_REQ-1:0] wr,
                        input logic [NUM_REQ*ADDR_W-1:0] addrs,
                        input logic [NUM_REQ*DATA_W-1:0] datas,
                        input int waits, input bit hold);
        int g, n;
        bit done, tmo, w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d, exp_rd;
        logic [NUM_REQ-1:0] exp_oh;
        g = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            int c;
            c = (exp_ptr + i) % NUM_REQ;
            if (g < 0 && mask[c]) g = c;
        end
        a = addrs[g*ADDR_W +: ADDR_W];
        d = datas[g*DATA_W +: DATA_W];
        w = wr[g];
        exp_oh = '0;
        exp_oh[g] = 1'b1;
        tmo = (waits < 0);

        req_valid = mask;
        req_write = wr;
        req_addr  = addrs;
        req_wdata = datas;
        PREADY    = 1'b1;
        tick;
        checks++;
        if (req_ready !== exp_oh) begin
            errors++;
            $display("FAIL grant: req_ready=%b expected=%b", req_ready, exp_oh);
        end
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b0) begin
            errors++;
            $display("FAIL setup_phase: PSEL=%b PENABLE=%b expected 1 0", PSEL, PENABLE);
        end
        checks++;
        if (PADDR !== a || PWRITE !== w || (w && PWDATA !== d)) begin
            errors++;
            $display("FAIL setup_bus: PADDR=%0d PWRITE=%b PWDATA=%h expected %0d %b %h",
                     PADDR, PWRITE, PWDATA, a, w, d);
        end
        exp_ptr = (g + 1) % NUM_REQ;
        if (!hold) req_valid = '0;
        tick;

        n = 0;
        done = 0;
        while (!done) begin
            checks++;
            if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PADDR !== a || PWRITE !== w ||
                (w && PWDATA !== d) || req_ready !== '0 || rsp_valid !== '0) begin
                errors++;
                $display("FAIL access_hold[%0d]: PSEL=%b PENABLE=%b PADDR=%0d req_ready=%b rsp_valid=%b expected 1 1 %0d 00 00",
                         n, PSEL, PENABLE, PADDR, req_ready, rsp_valid, a);
            end
            PREADY = !tmo && (n >= waits);
            tick;
            if (PREADY || (tmo && n == TIMEOUT - 1)) done = 1;
            else n++;
        end

        exp_rd = (w || tmo) ? '0 : ref_mem[a];
        checks++;
        if (rsp_valid !== exp_oh || rsp_err !== tmo || rsp_rdata !== exp_rd) begin
            errors++;
            $display("FAIL response: rsp_valid=%b rsp_err=%b rsp_rdata=%h expected %b %b %h",
                     rsp_valid, rsp_err, rsp_rdata, exp_oh, tmo, exp_rd);
        end
        checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin
            errors++;
            $display("FAIL bus_release: PSEL=%b PENABLE=%b expected 0 0", PSEL, PENABLE);
        end
        if (w && !tmo) ref_mem[a] = d;
        PREADY = 1'b1;
    endtask

    task automatic test_reset;
        PRESET = 1'b1;
        tick;
        tick;
        checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_rdata, rsp_err} !== '0) begin
            errors++;
            $display("FAIL reset_bus: PSEL=%b PENABLE=%b PWRITE=%b PADDR=%0d PWDATA=%h rsp_rdata=%h rsp_err=%b expected all 0",
                     PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_rdata, rsp_err);
        end
        checks++;
        if (req_ready !== '0 || rsp_valid !== '0) begin
            errors++;
            $display("FAIL reset_handshake: req_ready=%b rsp_valid=%b expected 00 00", req_ready, rsp_valid);
        end
        PRESET = 1'b0;
        exp_ptr = 0;
        tick;
    endtask

    task automatic test_single_write;
        xfer(2'b01, 2'b01, {3'd0, 3'd3}, {8'h00, 8'hA5}, 0, 0);
    endtask

    task automatic test_read_back;
        xfer(2'b10, 2'b00, {3'd3, 3'd0}, 16'h0000, 0, 0);
        checks++;
        if (ref_mem[3] !== 8'hA5) begin
            errors++;
            $display("FAIL read_back_model: ref=%h expected a5", ref_mem[3]);
        end
    endtask

    task automatic test_contention;
        for (int k = 0; k < 4; k++)
            xfer(2'b11, 2'b01, {3'(k + 4), 3'(k)}, {8'h00, 8'(8'h30 + k)}, 0, 1);
        req_valid = '0;
    endtask

    task automatic test_wait_states;
        xfer(2'b01, 2'b01, {3'd0, 3'd6}, {8'h00, 8'h5C}, 3, 0);
        xfer(2'b10, 2'b00, {3'd6, 3'd0}, 16'h0000, 3, 0);
    endtask

    task automatic test_timeout;
        xfer(2'b01, 2'b00, {3'd0, 3'd2}, 16'h0000, -1, 0);
        // FSM must be idle again: an immediate request is accepted next edge
        xfer(2'b10, 2'b10, {3'd1, 3'd0}, {8'h77, 8'h00}, 0, 0);
    endtask

    task automatic test_reset_mid_access;
        req_valid = 2'b01;
        req_write = 2'b01;
        req_addr  = {3'd0, 3'd5};
        req_wdata = {8'h00, 8'hEE};
        PREADY    = 1'b0;
        tick;
        req_valid = '0;
        tick;
        tick;
        PRESET = 1'b1;
        tick;
        checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
            errors++;
            $display("FAIL reset_mid_access: PSEL=%b PENABLE=%b PWRITE=%b PADDR=%0d rsp_valid=%b expected all 0",
                     PSEL, PENABLE, PWRITE, PADDR, rsp_valid);
        end
        PRESET  = 1'b0;
        PREADY  = 1'b1;
        exp_ptr = 0;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++;
            if (rsp_valid !== '0 || PSEL !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_quiet[%0d]: rsp_valid=%b PSEL=%b expected 00 0", k, rsp_valid, PSEL);
            end
        end
        xfer(2'b11, 2'b00, {3'd5, 3'd5}, 16'h0000, 0, 0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 12; k++) begin
            logic [NUM_REQ-1:0]        m, wr;
            logic [NUM_REQ*ADDR_W-1:0] ad;
            logic [NUM_REQ*DATA_W-1:0] dt;
            m  = NUM_REQ'($urandom_range(1, 3));
            wr = NUM_REQ'($urandom);
            ad = (NUM_REQ*ADDR_W)'($urandom);
            dt = (NUM_REQ*DATA_W)'($urandom);
            xfer(m, wr, ad, dt, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end
        req_valid = '0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            slave_mem[i] = 8'(i * 17);
            ref_mem[i]   = 8'(i * 17);
        end
        PRESET    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        PREADY    = 1'b1;

        test_reset;
        test_single_write;
        test_read_back;
        test_contention;
        test_wait_states;
        test_timeout;
        test_reset_mid_access;
        test_random;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
